// File: rtl/inst_fetch_pkg.sv
// Shared constants, bus types and helpers for the instruction-fetch stage.
package inst_fetch_pkg;

    localparam logic RST_ENABLE  = 1'b0;
    localparam int   INST_ADDR_W = 32;
    localparam int   INST_W      = 32;

    typedef logic [INST_ADDR_W-1:0] inst_addr_bus_t;
    typedef logic [INST_W-1:0]      inst_bus_t;

    localparam inst_addr_bus_t INST_BYTES = 32'd4;
    localparam inst_bus_t      NOP_INST   = 32'h0000_0000;
    localparam inst_addr_bus_t ZERO_V     = 32'h0000_0000;

    typedef struct packed {
        inst_addr_bus_t addr;
        inst_bus_t      inst;
    } fetch_entry_t;

    function automatic inst_addr_bus_t word_align(input inst_addr_bus_t addr);
        return addr & ~inst_addr_bus_t'(INST_BYTES - 32'd1);
    endfunction

endpackage

// File: rtl/inst_fetch_fifo.sv
// Small synchronous FIFO with flush; holds fetched {addr, inst} pairs for decode.
module inst_fetch_fifo
    import inst_fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 64,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
    assign rdata   = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; flush empties the buffer outright
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is written on push only; count gates visibility so no reset is needed
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: PC, credit-limited in-order requests, response drop after redirect.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [INST_ADDR_W-1:0] RESET_PC   = 32'h0000_0000,
    parameter int                     FIFO_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall_i,
    input  logic                   redirect_i,
    input  logic [INST_ADDR_W-1:0] redirect_addr_i,
    output logic                   imem_req_o,
    output logic [INST_ADDR_W-1:0] imem_addr_o,
    input  logic                   imem_gnt_i,
    input  logic                   imem_rvalid_i,
    input  logic [INST_W-1:0]      imem_rdata_i,
    output logic                   inst_valid_o,
    output logic [INST_ADDR_W-1:0] inst_addr_o,
    output logic [INST_W-1:0]      inst_o
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0] CREDIT_LIMIT = (CW + 1)'(FIFO_DEPTH);

    inst_addr_bus_t fetch_pc;
    inst_addr_bus_t resp_pc;
    logic [CW-1:0]  inflight;
    logic [CW-1:0]  inflight_next;
    logic [CW-1:0]  drop_cnt;
    logic [CW-1:0]  count;
    logic [CW:0]    credit_used;
    logic           issue;
    logic           fifo_push;
    logic           fifo_pop;
    fetch_entry_t   push_entry;
    fetch_entry_t   head_entry;

    assign credit_used = {1'b0, inflight} + {1'b0, count};
    assign imem_req_o  = (rst != RST_ENABLE) && !redirect_i && (credit_used < CREDIT_LIMIT);
    assign imem_addr_o = fetch_pc;
    assign issue       = imem_req_o && imem_gnt_i;

    assign fifo_push   = imem_rvalid_i && !redirect_i && (drop_cnt == '0);
    assign fifo_pop    = inst_valid_o && !stall_i && !redirect_i;
    assign push_entry  = '{addr: resp_pc, inst: imem_rdata_i};

    assign inst_valid_o = (count != '0);
    assign inst_addr_o  = inst_valid_o ? head_entry.addr : ZERO_V;
    assign inst_o       = inst_valid_o ? head_entry.inst : NOP_INST;

    // Outstanding requests: plus one per grant, minus one per returned word
    always_comb begin
        inflight_next = inflight;
        case ({issue, imem_rvalid_i})
            2'b10:   inflight_next = inflight + CW'(1);
            2'b01:   inflight_next = (inflight != '0) ? inflight - CW'(1) : inflight;
            default: inflight_next = inflight;
        endcase
    end

    // PCs and drop counter; a redirect reloads both PCs and marks every in-flight word for discard
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            inflight <= '0;
            drop_cnt <= '0;
        end else begin
            inflight <= inflight_next;
            if (redirect_i) begin
                fetch_pc <= word_align(redirect_addr_i);
                resp_pc  <= word_align(redirect_addr_i);
                drop_cnt <= inflight_next;
            end else begin
                if (issue) fetch_pc <= fetch_pc + INST_BYTES;
                if (imem_rvalid_i) begin
                    if (drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
                    else                resp_pc  <= resp_pc + INST_BYTES;
                end
            end
        end
    end

    inst_fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (redirect_i),
        .wdata (push_entry),
        .rdata (head_entry),
        .count (count)
    );

endmodule

// File: tb/tb_inst_fetch.sv
// Randomised bench for inst_fetch: memory environment plus a path-epoch reference model.
module tb_inst_fetch;

    localparam logic [31:0] TB_RESET_PC = 32'hFFFF_FFF8;
    localparam int          DEPTH       = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_addr_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        inst_valid_o;
    logic [31:0] inst_addr_o;
    logic [31:0] inst_o;

    int vectors    = 0;
    int miscompares = 0;

    logic [31:0] m_fetch_pc;
    int          epoch;
    int          cyc;
    logic [31:0] pend_maddr [$];
    logic [31:0] pend_daddr [$];
    int          pend_epoch [$];
    int          pend_ready [$];
    logic [31:0] exp_addr [$];
    logic [31:0] exp_inst [$];

    int          p_stall;
    int          p_redirect;
    int          p_gnt;
    int          p_rsp;
    int          lat_min;
    int          lat_max;
    bit          force_redirect;
    logic [31:0] force_addr;
    bit          just_released;
    bit          issue_s;
    logic [31:0] issue_addr_s;

    inst_fetch #(
        .RESET_PC   (TB_RESET_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall_i         (stall_i),
        .redirect_i      (redirect_i),
        .redirect_addr_i (redirect_addr_i),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_gnt_i      (imem_gnt_i),
        .imem_rvalid_i   (imem_rvalid_i),
        .imem_rdata_i    (imem_rdata_i),
        .inst_valid_o    (inst_valid_o),
        .inst_addr_o     (inst_addr_o),
        .inst_o          (inst_o)
    );

    // Free-running 10-unit clock
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %08h, expected %08h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic checkOutput();
        if (exp_addr.size() != 0) begin
            checkValue("inst_valid", {31'b0, inst_valid_o}, 32'd1);
            checkValue("inst_addr", inst_addr_o, exp_addr[0]);
            checkValue("inst", inst_o, exp_inst[0]);
        end else begin
            checkValue("inst_valid", {31'b0, inst_valid_o}, 32'd0);
            checkValue("inst_addr_idle", inst_addr_o, 32'h0);
            checkValue("inst_idle", inst_o, 32'h0);
        end
        checkValue("imem_addr", imem_addr_o, m_fetch_pc);
    endtask

    task automatic applyStimulus();
        stall_i = ($urandom_range(99) < p_stall);
        if (force_redirect) begin
            redirect_i      = 1'b1;
            redirect_addr_i = force_addr;
            force_redirect  = 1'b0;
        end else begin
            redirect_i      = ($urandom_range(99) < p_redirect);
            redirect_addr_i = $urandom;
        end
        imem_gnt_i = ($urandom_range(99) < p_gnt);
        if (pend_ready.size() != 0 && pend_ready[0] <= cyc && $urandom_range(99) < p_rsp) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = mem_word(pend_daddr[0]);
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = $urandom;
        end
    endtask

    task automatic checkIssue();
        bit exp_req;
        exp_req = !redirect_i && ((pend_maddr.size() + exp_addr.size()) < DEPTH);
        checkValue("imem_req", {31'b0, imem_req_o}, {31'b0, exp_req});
        issue_s      = imem_req_o && imem_gnt_i;
        issue_addr_s = imem_addr_o;
    endtask

    task automatic updateModel();
        bit          keep;
        logic [31:0] ka;
        int          ep;
        keep = 1'b0;
        ka   = '0;
        if (imem_rvalid_i) begin
            ka = pend_maddr.pop_front();
            ep = pend_epoch.pop_front();
            void'(pend_daddr.pop_front());
            void'(pend_ready.pop_front());
            keep = (ep == epoch) && !redirect_i;
        end
        if (issue_s) begin
            pend_maddr.push_back(m_fetch_pc);
            pend_daddr.push_back(issue_addr_s);
            pend_epoch.push_back(epoch);
            pend_ready.push_back(cyc + $urandom_range(lat_max, lat_min));
        end
        if (redirect_i) begin
            exp_addr.delete();
            exp_inst.delete();
            epoch++;
            m_fetch_pc = {redirect_addr_i[31:2], 2'b00};
        end else begin
            if (exp_addr.size() != 0 && !stall_i) begin
                void'(exp_addr.pop_front());
                void'(exp_inst.pop_front());
            end
            if (keep) begin
                exp_addr.push_back(ka);
                exp_inst.push_back(mem_word(ka));
            end
            if (issue_s) m_fetch_pc = m_fetch_pc + 32'd4;
        end
        cyc++;
    endtask

    task automatic stepBody();
        checkOutput();
        applyStimulus();
        #1;
        checkIssue();
        if (just_released && !redirect_i) checkValue("first_fetch", {31'b0, imem_req_o}, 32'd1);
        just_released = 1'b0;
        @(posedge clk);
        updateModel();
    endtask

    task automatic stepCycle();
        @(negedge clk);
        stepBody();
    endtask

    task automatic doReset();
        @(negedge clk);
        #2;
        rst           = 1'b0;
        stall_i       = 1'b0;
        redirect_i    = 1'b0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        #1;
        checkValue("rst_valid", {31'b0, inst_valid_o}, 32'd0);
        checkValue("rst_inst", inst_o, 32'h0);
        checkValue("rst_inst_addr", inst_addr_o, 32'h0);
        checkValue("rst_req", {31'b0, imem_req_o}, 32'd0);
        checkValue("rst_imem_addr", imem_addr_o, TB_RESET_PC);
        pend_maddr.delete();
        pend_daddr.delete();
        pend_epoch.delete();
        pend_ready.delete();
        exp_addr.delete();
        exp_inst.delete();
        m_fetch_pc = TB_RESET_PC;
        epoch++;
        repeat (2) @(negedge clk);
        rst           = 1'b1;
        just_released = 1'b1;
        stepBody();
    endtask

    task automatic expectSeq(input string name, input logic [31:0] e0, input logic [31:0] e1);
        logic [31:0] seen [$];
        for (int i = 0; i < 16 && seen.size() < 2; i++) begin
            stepCycle();
            #1;
            if (inst_valid_o) seen.push_back(inst_addr_o);
        end
        while (seen.size() < 2) seen.push_back(32'hDEAD_BEEF);
        checkValue({name, "_first"}, seen[0], e0);
        checkValue({name, "_second"}, seen[1], e1);
    endtask

    // Hard stop in case any bounded loop misbehaves
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios followed by a long randomised run
    initial begin
        rst = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_addr_i = '0;
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
        p_stall = 0; p_redirect = 0; p_gnt = 100; p_rsp = 100; lat_min = 1; lat_max = 1;
        force_redirect = 1'b0; force_addr = '0; just_released = 1'b0;
        issue_s = 1'b0; issue_addr_s = '0;
        m_fetch_pc = TB_RESET_PC; epoch = 0; cyc = 0;

        repeat (2) @(negedge clk);
        #1;
        checkValue("reset_req", {31'b0, imem_req_o}, 32'd0);
        checkValue("reset_imem_addr", imem_addr_o, TB_RESET_PC);
        checkValue("reset_valid", {31'b0, inst_valid_o}, 32'd0);
        checkValue("reset_inst", inst_o, 32'h0);
        checkValue("reset_inst_addr", inst_addr_o, 32'h0);

        @(negedge clk);
        rst = 1'b1;
        just_released = 1'b1;
        stepBody();
        #1;
        checkValue("stream_t1_valid", {31'b0, inst_valid_o}, 32'd0);
        stepCycle();
        #1;
        checkValue("stream_t2_valid", {31'b0, inst_valid_o}, 32'd1);
        checkValue("stream_t2_addr", inst_addr_o, 32'hFFFF_FFF8);
        expectSeq("stream_wrap", 32'hFFFF_FFFC, 32'h0000_0000);
        expectSeq("stream_more", 32'h0000_0004, 32'h0000_0008);

        p_stall = 100;
        for (int i = 0; i < 5; i++) begin
            stepCycle();
            #1;
            checkValue("stall_hold_valid", {31'b0, inst_valid_o}, 32'd1);
            checkValue("stall_hold_addr", inst_addr_o, 32'h0000_0008);
        end
        checkValue("stall_req_low", {31'b0, imem_req_o}, 32'd0);
        p_stall = 0;
        expectSeq("stall_resume", 32'h0000_000C, 32'h0000_0010);

        lat_min = 3; lat_max = 3;
        for (int i = 0; i < 20 && pend_maddr.size() != 2; i++) stepCycle();
        force_redirect = 1'b1;
        force_addr     = 32'h0000_1002;
        stepCycle();
        #1;
        checkValue("redir_flush_valid", {31'b0, inst_valid_o}, 32'd0);
        expectSeq("redir_inflight", 32'h0000_1000, 32'h0000_1004);

        lat_min = 1; lat_max = 1;
        repeat (4) stepCycle();
        force_redirect = 1'b1;
        force_addr     = 32'h2000_0007;
        stepCycle();
        #1;
        checkValue("redir_same_valid", {31'b0, inst_valid_o}, 32'd0);
        expectSeq("redir_same", 32'h2000_0004, 32'h2000_0008);

        p_stall = 100;
        repeat (6) stepCycle();
        #1;
        checkValue("full_before_rst", {31'b0, inst_valid_o}, 32'd1);
        p_stall = 0;
        doReset();
        expectSeq("restart", 32'hFFFF_FFF8, 32'hFFFF_FFFC);

        p_stall = 30; p_redirect = 5; p_gnt = 70; p_rsp = 75; lat_min = 1; lat_max = 4;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(499) == 0) doReset();
            else                          stepCycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
